// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: word width, control tokens,
// alignment FSM states and the bit-offset stepping helper.
package tmds_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] TOK_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] TOK_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] TOK_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] TOK_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_e;

    // Bit offsets run 0..9 and wrap back to 0
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off >= 4'd9) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decoder: control-token match plus
// 8-bit data recovery from an aligned 10-bit word.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [TMDS_W-1:0] i_word,
    output logic              o_is_token,
    output logic [1:0]        o_c1c0,
    output logic [7:0]        o_data
);

    logic [7:0] d;

    // Token lookup, then undo the optional inversion and xor/xnor chain
    always_comb begin
        o_is_token = 1'b1;
        o_c1c0     = 2'b00;
        case (i_word)
            TOK_00:  o_c1c0 = 2'b00;
            TOK_01:  o_c1c0 = 2'b01;
            TOK_10:  o_c1c0 = 2'b10;
            TOK_11:  o_c1c0 = 2'b11;
            default: o_is_token = 1'b0;
        endcase

        d = i_word[9] ? ~i_word[7:0] : i_word[7:0];
        o_data    = 8'h00;
        o_data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o_data[i] = i_word[8] ? (d[i] ^ d[i-1])
                                  : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/dvi_decoder_channel.sv
// One TMDS lane receiver: bit-slip word alignment locked on control
// token runs, followed by a two-stage decode pipeline.
module dvi_decoder_channel
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOCK_TIMEOUT   = 4096
)(
    input  logic              clk_hdmi,
    input  logic              reset,
    input  logic [TMDS_W-1:0] i_tmds_word,
    output logic [7:0]        o_data,
    output logic              o_c0,
    output logic              o_c1,
    output logic              o_de,
    output logic              o_locked,
    output logic [3:0]        o_offset,
    output logic              o_realign
);

    localparam int IDLE_MAX =
        (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
    localparam int RUN_W  = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
    localparam int IDLE_W = (IDLE_MAX > 1) ? $clog2(IDLE_MAX) : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
    localparam logic [IDLE_W-1:0] SRCH_LAST = IDLE_W'(SEARCH_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] LOCK_LAST = IDLE_W'(LOCK_TIMEOUT - 1);

    logic [TMDS_W-1:0]   prev_q, prev_d;
    logic [TMDS_W-1:0]   aligned_q, aligned_d;
    logic [2*TMDS_W-1:0] window;

    align_state_e        state_q, state_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [3:0]          offset_q, offset_d;
    logic                realign_q, realign_d;

    logic [7:0]          data_q, data_d;
    logic                c0_q, c0_d;
    logic                c1_q, c1_d;
    logic                de_q, de_d;

    logic                tok;
    logic [1:0]          tok_c1c0;
    logic [7:0]          dec_data;

    // Stage 1 input: pick a 10-bit window spanning this and last word
    always_comb begin
        prev_d    = i_tmds_word;
        window    = {i_tmds_word, prev_q} >> offset_q;
        aligned_d = window[TMDS_W-1:0];
    end

    tmds_word_decode u_decode (
        .i_word     (aligned_q),
        .o_is_token (tok),
        .o_c1c0     (tok_c1c0),
        .o_data     (dec_data)
    );

    // Stage 2 input: tokens update c1/c0, data words keep them
    always_comb begin
        data_d = data_q;
        c0_d   = c0_q;
        c1_d   = c1_q;
        de_d   = de_q;
        if (tok) begin
            de_d   = 1'b0;
            data_d = 8'h00;
            c1_d   = tok_c1c0[1];
            c0_d   = tok_c1c0[0];
        end else begin
            de_d   = 1'b1;
            data_d = dec_data;
        end
    end

    // Alignment FSM: count token runs to lock, idle cycles to slip
    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        idle_cnt_d = idle_cnt_q;
        offset_d   = offset_q;
        realign_d  = 1'b0;
        case (state_q)
            SEARCH: begin
                if (tok) begin
                    idle_cnt_d = '0;
                    if (run_cnt_q >= RUN_LAST) begin
                        state_d   = LOCKED;
                        run_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end else begin
                    run_cnt_d = '0;
                    if (idle_cnt_q >= SRCH_LAST) begin
                        offset_d   = next_offset(offset_q);
                        realign_d  = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                run_cnt_d = '0;
                if (tok) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= LOCK_LAST) begin
                    state_d    = SEARCH;
                    offset_d   = next_offset(offset_q);
                    realign_d  = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Pipeline and alignment state registers
    always_ff @(posedge clk_hdmi) begin
        if (reset) begin
            prev_q     <= '0;
            aligned_q  <= '0;
            state_q    <= SEARCH;
            run_cnt_q  <= '0;
            idle_cnt_q <= '0;
            offset_q   <= '0;
            realign_q  <= 1'b0;
            data_q     <= '0;
            c0_q       <= 1'b0;
            c1_q       <= 1'b0;
            de_q       <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            aligned_q  <= aligned_d;
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            offset_q   <= offset_d;
            realign_q  <= realign_d;
            data_q     <= data_d;
            c0_q       <= c0_d;
            c1_q       <= c1_d;
            de_q       <= de_d;
        end
    end

    assign o_locked  = (state_q == LOCKED);
    assign o_data    = o_locked ? data_q : 8'h00;
    assign o_de      = o_locked & de_q;
    assign o_c0      = o_locked & c0_q;
    assign o_c1      = o_locked & c1_q;
    assign o_offset  = offset_q;
    assign o_realign = realign_q;

endmodule

// File: tb/tb_dvi_decoder_channel.sv
// Directed-vector bench for one TMDS lane decoder: lock, bit slip,
// data decode, run breaks, lock loss and mid-run reset.
module tb_dvi_decoder_channel;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] D00 = 10'h100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] i_tmds_word = '0;
    logic [7:0] o_data;
    logic       o_c0, o_c1, o_de, o_locked, o_realign;
    logic [3:0] o_offset;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dvi_decoder_channel dut (
        .clk_hdmi    (clk),
        .reset       (reset),
        .i_tmds_word (i_tmds_word),
        .o_data      (o_data),
        .o_c0        (o_c0),
        .o_c1        (o_c1),
        .o_de        (o_de),
        .o_locked    (o_locked),
        .o_offset    (o_offset),
        .o_realign   (o_realign)
    );

    task automatic step(input logic [9:0] w);
        i_tmds_word = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(10'h000);
        step(10'h000);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(T00);
        step(T00);
        total++;
        if ({o_data, o_c0, o_c1, o_de} !== 11'd0) begin
            bad++;
            $display("FAIL reset_out: got %h/%b%b%b want 0",
                     o_data, o_c0, o_c1, o_de);
        end
        total++;
        if ({o_locked, o_offset, o_realign} !== 6'd0) begin
            bad++;
            $display("FAIL reset_align: got %b/%0d/%b want 0/0/0",
                     o_locked, o_offset, o_realign);
        end
        reset = 1'b0;
    endtask

    task automatic test_lock_offset0();
        int rc = 0;
        do_reset();
        for (int s = 1; s <= 20; s++) begin
            step(T00);
            if (o_realign) rc++;
            if (s == 9) begin
                total++;
                if (o_locked !== 1'b0) begin
                    bad++;
                    $display("FAIL lock0_early: got %b want 0", o_locked);
                end
            end
            if (s == 10) begin
                total++;
                if (o_locked !== 1'b1) begin
                    bad++;
                    $display("FAIL lock0_at10: got %b want 1", o_locked);
                end
            end
        end
        total++;
        if ({o_de, o_c1, o_c0, o_data} !== 11'd0) begin
            bad++;
            $display("FAIL lock0_ctrl: got de=%b c=%b%b d=%h want 0",
                     o_de, o_c1, o_c0, o_data);
        end
        total++;
        if (o_offset !== 4'd0 || rc != 0) begin
            bad++;
            $display("FAIL lock0_slip: got off=%0d pulses=%0d want 0/0",
                     o_offset, rc);
        end
    endtask

    task automatic test_slip();
        int rs[3];
        int ro[3];
        int nr = 0;
        int lock_step = -1;
        int want_rs[3] = '{4096, 8192, 12288};
        do_reset();
        for (int s = 1; s <= 12400; s++) begin
            step(10'h15D);
            if (o_realign) begin
                if (nr < 3) begin
                    rs[nr] = s;
                    ro[nr] = int'(o_offset);
                end
                nr++;
            end
            if (o_locked && lock_step < 0) lock_step = s;
        end
        total++;
        if (nr != 3) begin
            bad++;
            $display("FAIL slip_count: got %0d want 3", nr);
        end
        for (int k = 0; k < 3 && k < nr; k++) begin
            total++;
            if (rs[k] != want_rs[k] || ro[k] != k + 1) begin
                bad++;
                $display("FAIL slip_%0d: got step %0d off %0d want %0d/%0d",
                         k, rs[k], ro[k], want_rs[k], k + 1);
            end
        end
        total++;
        if (lock_step != 12297) begin
            bad++;
            $display("FAIL slip_lock_step: got %0d want 12297", lock_step);
        end
        total++;
        if (o_offset !== 4'd3 || {o_c1, o_c0} !== 2'b11 || o_de !== 1'b0) begin
            bad++;
            $display("FAIL slip_final: got off=%0d c=%b%b de=%b want 3/11/0",
                     o_offset, o_c1, o_c0, o_de);
        end
    endtask

    task automatic test_data();
        logic [9:0] w[7]  = '{10'h100, 10'h200, 10'h1A5, 10'h25A,
                              T10, T10, T10};
        logic [7:0] ed[7] = '{8'h00, 8'h00, 8'h00, 8'hFF,
                              8'hEF, 8'h11, 8'h00};
        logic       ee[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] ec[7] = '{2'b01, 2'b01, 2'b01, 2'b01,
                              2'b01, 2'b01, 2'b10};
        do_reset();
        for (int s = 1; s <= 12; s++) step(T01);
        for (int j = 0; j < 7; j++) begin
            step(w[j]);
            total++;
            if (o_de !== ee[j] || o_data !== ed[j]) begin
                bad++;
                $display("FAIL data_%0d: got de=%b d=%h want %b/%h",
                         j, o_de, o_data, ee[j], ed[j]);
            end
            total++;
            if ({o_c1, o_c0} !== ec[j] || o_locked !== 1'b1) begin
                bad++;
                $display("FAIL ctrl_%0d: got c=%b%b lk=%b want %b/1",
                         j, o_c1, o_c0, o_locked, ec[j]);
            end
        end
    endtask

    task automatic test_run_break();
        int early = 0;
        do_reset();
        for (int s = 1; s <= 23; s++) begin
            step((s == 8) ? D00 : T00);
            if (s <= 17 && o_locked) early++;
            if (s == 18) begin
                total++;
                if (o_locked !== 1'b1) begin
                    bad++;
                    $display("FAIL run_relock: got %b want 1", o_locked);
                end
            end
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL run_break: locked %0d cycles want 0", early);
        end
    endtask

    task automatic test_lock_timeout(input bit tok_last);
        int rc = 0;
        do_reset();
        for (int s = 1; s <= 4112; s++) begin
            if (s <= 12) step(T00);
            else if (s == 4108 && tok_last) step(T00);
            else step(D00);
            if (o_realign) rc++;
            if (s == 4109) begin
                total++;
                if (o_locked !== 1'b1 || o_de !== 1'b1) begin
                    bad++;
                    $display("FAIL lto_%0d_pre: got lk=%b de=%b want 1/1",
                             tok_last, o_locked, o_de);
                end
            end
            if (s == 4110) begin
                total++;
                if (o_locked !== tok_last ||
                    o_offset !== (tok_last ? 4'd0 : 4'd1) ||
                    o_realign !== !tok_last) begin
                    bad++;
                    $display("FAIL lto_%0d_edge: got lk=%b off=%0d rl=%b",
                             tok_last, o_locked, o_offset, o_realign);
                end
            end
            if (s == 4111) begin
                total++;
                if (o_de !== tok_last || o_locked !== tok_last) begin
                    bad++;
                    $display("FAIL lto_%0d_after: got de=%b lk=%b want %b",
                             tok_last, o_de, o_locked, tok_last);
                end
            end
        end
        total++;
        if (rc != (tok_last ? 0 : 1)) begin
            bad++;
            $display("FAIL lto_%0d_pulses: got %0d want %0d",
                     tok_last, rc, tok_last ? 0 : 1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int s = 1; s <= 20481; s++) step(D00);
        total++;
        if (o_offset !== 4'd5 || o_locked !== 1'b0) begin
            bad++;
            $display("FAIL mid_pre: got off=%0d lk=%b want 5/0",
                     o_offset, o_locked);
        end
        reset = 1'b1;
        step(D00);
        total++;
        if ({o_offset, o_locked, o_data, o_de, o_c0, o_c1, o_realign}
            !== 17'd0) begin
            bad++;
            $display("FAIL mid_reset: got off=%0d lk=%b d=%h de=%b",
                     o_offset, o_locked, o_data, o_de);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_offset0();
        test_slip();
        test_data();
        test_run_break();
        test_lock_timeout(1'b0);
        test_lock_timeout(1'b1);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
